shifter_pipe: RTL

//   Parametrised, pipelined barrel shifter for the execute stage; successor to the 16-bit/4-bit

---
 rtl/shifter_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter with valid/ready flow control on both sides
// ROTATE_EN (optional define) adds ROL/ROR on op codes 100/101; otherwise every 1xx code is illegal.
module shifter_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  localparam int SW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [SW-1:0]    shf,
  input  logic [2:0]       sigs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             out_zero,
  output logic             out_ill
);
  localparam int LEVELS = SW;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
`ifdef ROTATE_EN
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
`endif

  // One binary level: shift d by amt (a power of two) using the fill rule of op.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       op,
                                                   input logic             sign,
                                                   input int               amt);
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (op)
      OP_SLL:  shift_level = d << amt;
      OP_SRL:  shift_level = d >> amt;
      OP_SRA:  shift_level = (d >> amt) | (sign ? ~(ones >> amt) : '0);
`ifdef ROTATE_EN
      OP_ROL:  shift_level = (d << amt) | (d >> (WIDTH - amt));
      OP_ROR:  shift_level = (d >> amt) | (d << (WIDTH - amt));
`endif
      default: shift_level = d;
    endcase
  endfunction

  // Illegal codes travel as a plain pass so B = A with the ill flag set.
  logic       ill_dec;
  logic [2:0] op_dec;
  always_comb begin
`ifdef ROTATE_EN
    ill_dec = sigs[2] & sigs[1];
`else
    ill_dec = sigs[2];
`endif
    op_dec = ill_dec ? OP_PASS : sigs;
  end

  logic [STAGES-1:0] valid_vec;
  logic [STAGES:0]   ready;

  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = ~valid_vec[k] | ready[k+1];
    end
  end

  assign in_ready = ready[0] & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             sg_in;
    logic             il_in;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [2:0]       o_in;
    logic [SW-1:0]    s_in;
    logic             valid_q;
    logic             ill_q;
    logic [WIDTH-1:0] data_q;

    if (k == 0) begin : g_src
      assign v_in  = in_valid;
      assign d_in  = A;
      assign o_in  = op_dec;
      assign s_in  = shf;
      assign sg_in = A[WIDTH-1];
      assign il_in = ill_dec;
    end else begin : g_src
      assign v_in  = g_stage[k-1].valid_q;
      assign d_in  = g_stage[k-1].data_q;
      assign o_in  = g_stage[k-1].g_carry.op_q;
      assign s_in  = g_stage[k-1].g_carry.shf_q;
      assign sg_in = g_stage[k-1].g_carry.sign_q;
      assign il_in = g_stage[k-1].ill_q;
    end

    // Level j is owned by stage floor(j*STAGES/LEVELS).
    always_comb begin
      d_out = d_in;
      for (int j = 0; j < LEVELS; j++) begin
        if (((j * STAGES) / LEVELS == k) && s_in[j]) begin
          d_out = shift_level(d_out, o_in, sg_in, 1 << j);
        end
      end
    end

    assign valid_vec[k] = valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        ill_q   <= 1'b0;
      end else if (ready[k]) begin
        valid_q <= v_in;
        data_q  <= d_out;
        ill_q   <= il_in;
      end
    end

    if (k < STAGES - 1) begin : g_carry
      logic [2:0]    op_q;
      logic [SW-1:0] shf_q;
      logic          sign_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          op_q   <= '0;
          shf_q  <= '0;
          sign_q <= 1'b0;
        end else if (ready[k]) begin
          op_q   <= o_in;
          shf_q  <= s_in;
          sign_q <= sg_in;
        end
      end
    end else begin : g_last
      logic zero_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          zero_q <= 1'b0;
        end else if (ready[k]) begin
          zero_q <= (d_out == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign B         = g_stage[STAGES-1].data_q;
  assign out_ill   = g_stage[STAGES-1].ill_q;
  assign out_zero  = g_stage[STAGES-1].g_last.zero_q;

endmodule
